// File: rtl/lsu_ctrl_mo.sv
//==============================================================================
// Module      : lsu_ctrl_mo
// Description : Load/store control unit between the AGU and the DTCM. It keeps
//               up to OSD commands in flight and retires them strictly in order.
//               Build option LSU_MISALGN_CHK_EN enables misaligned-access errors.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lsu_ctrl_mo #(
    parameter  int XLEN   = 32,
    parameter  int AW     = 16,
    parameter  int ITAG_W = 1,
    parameter  int OSD    = 2,
    localparam int CW     = $clog2(OSD + 1)
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                agu_cmd_valid,
    output logic                agu_cmd_ready,
    input  logic                agu_cmd_read,
    input  logic [AW-1:0]       agu_cmd_addr,
    input  logic [XLEN-1:0]     agu_cmd_wdata,
    input  logic [1:0]          agu_cmd_size,
    input  logic                agu_cmd_usign,
    input  logic [ITAG_W-1:0]   agu_cmd_itag,

    output logic                dtcm_cmd_valid,
    input  logic                dtcm_cmd_ready,
    output logic                dtcm_cmd_read,
    output logic [AW-1:0]       dtcm_cmd_addr,
    output logic [XLEN-1:0]     dtcm_cmd_wdata,
    output logic [XLEN/8-1:0]   dtcm_cmd_wmask,

    input  logic                dtcm_rsp_valid,
    output logic                dtcm_rsp_ready,
    input  logic [XLEN-1:0]     dtcm_rsp_rdata,

    output logic                lsu_o_valid,
    input  logic                lsu_o_ready,
    output logic [XLEN-1:0]     lsu_o_wbck_data,
    output logic [ITAG_W-1:0]   lsu_o_wbck_itag,
    output logic                lsu_o_wbck_err,
    output logic [CW-1:0]       lsu_o_outstanding
);

    localparam int         PW         = (OSD > 1) ? $clog2(OSD) : 1;
    localparam logic [1:0] c_SZ_BYTE  = 2'b00;
    localparam logic [1:0] c_SZ_HALF  = 2'b01;

    typedef struct packed {
        logic [ITAG_W-1:0] itag;
        logic              read;
        logic              usign;
        logic [1:0]        size;
        logic [1:0]        lsb;
        logic              err;
    } entry_t;

    entry_t          r_fifo [OSD];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_cnt;

    logic            w_full;
    logic            w_empty;
    logic            w_mis;
    logic            w_push;
    logic            w_pop;
    entry_t          w_head;
    entry_t          w_new;
    logic [XLEN-1:0] w_shift;

    // Pointers wrap explicitly so OSD need not be a power of two.
    function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] ptr);
        if (ptr == PW'(OSD - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    assign w_full  = (r_cnt == CW'(OSD));
    assign w_empty = (r_cnt == '0);

`ifdef LSU_MISALGN_CHK_EN
    always_comb begin
        w_mis = 1'b0;
        case (agu_cmd_size)
            c_SZ_BYTE: w_mis = 1'b0;
            c_SZ_HALF: w_mis = agu_cmd_addr[0];
            default:   w_mis = |agu_cmd_addr[1:0];
        endcase
    end
`else
    assign w_mis = 1'b0;
`endif

    //--------------------------------------------------------------------------
    // Command path
    //--------------------------------------------------------------------------
    assign dtcm_cmd_valid = agu_cmd_valid & ~w_full & ~w_mis;
    // Deliberately ignores same-cycle pops so there is no ready-to-ready path.
    assign agu_cmd_ready  = ~w_full & (w_mis | dtcm_cmd_ready);
    assign w_push         = agu_cmd_valid & agu_cmd_ready;

    assign dtcm_cmd_read  = agu_cmd_read;
    assign dtcm_cmd_addr  = agu_cmd_addr;

    always_comb begin
        dtcm_cmd_wmask = 4'b0000;
        dtcm_cmd_wdata = agu_cmd_wdata;
        case (agu_cmd_size)
            c_SZ_BYTE: begin
                dtcm_cmd_wmask = 4'b0001 << agu_cmd_addr[1:0];
                dtcm_cmd_wdata = {4{agu_cmd_wdata[7:0]}};
            end
            c_SZ_HALF: begin
                dtcm_cmd_wmask = 4'b0011 << agu_cmd_addr[1:0];
                dtcm_cmd_wdata = {2{agu_cmd_wdata[15:0]}};
            end
            default: begin
                dtcm_cmd_wmask = 4'b1111;
                dtcm_cmd_wdata = agu_cmd_wdata;
            end
        endcase
        if (agu_cmd_read) begin
            dtcm_cmd_wmask = 4'b0000;
        end
    end

    always_comb begin
        w_new       = '0;
        w_new.itag  = agu_cmd_itag;
        w_new.read  = agu_cmd_read;
        w_new.usign = agu_cmd_usign;
        w_new.size  = agu_cmd_size;
        w_new.lsb   = agu_cmd_addr[1:0];
        w_new.err   = w_mis;
    end

    //--------------------------------------------------------------------------
    // Response path
    //--------------------------------------------------------------------------
    assign w_head          = r_fifo[r_rptr];
    assign lsu_o_valid     = ~w_empty & (w_head.err | dtcm_rsp_valid);
    // Error entries never went to the DTCM, so they must not consume a response.
    assign dtcm_rsp_ready  = ~w_empty & ~w_head.err & lsu_o_ready;
    assign w_pop           = lsu_o_valid & lsu_o_ready;
    assign lsu_o_wbck_itag = w_head.itag;

`ifdef LSU_MISALGN_CHK_EN
    assign lsu_o_wbck_err  = ~w_empty & w_head.err;
`else
    assign lsu_o_wbck_err  = 1'b0;
`endif

    assign w_shift = dtcm_rsp_rdata >> {w_head.lsb, 3'b000};

    always_comb begin
        lsu_o_wbck_data = '0;
        if (w_head.read && !w_head.err) begin
            case (w_head.size)
                c_SZ_BYTE: lsu_o_wbck_data = w_head.usign ? {24'd0, w_shift[7:0]}
                                                          : {{24{w_shift[7]}}, w_shift[7:0]};
                c_SZ_HALF: lsu_o_wbck_data = w_head.usign ? {16'd0, w_shift[15:0]}
                                                          : {{16{w_shift[15]}}, w_shift[15:0]};
                default:   lsu_o_wbck_data = w_shift;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Tracker state
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_new;
                r_wptr         <= f_next_ptr(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_next_ptr(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign lsu_o_outstanding = r_cnt;

endmodule

`default_nettype wire
